mem_responder: RTL

Memory-side responder for the multi-cycle processor's instruction fetch and load/store traffic. It holds both the text (instruction) bank and the data bank, each 65536 x 16. It accepts one request at a time over a valid/ready handshake and returns the result after a programmable latency over a second valid/ready handshake. A preload port lets the bench or boot logic fill either bank while the responder is idle.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_bank.sv | 22 ++
 rtl/mem_responder.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, bank selectors and FSM state encoding for the memory responder.
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  localparam logic SPACE_TEXT = 1'b0;
  localparam logic SPACE_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake plus preload port between a processor (master) and the responder (slave).
interface mem_responder_if;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_space;
  logic                       req_write;
  logic [mem_pkg::ADDR_W-1:0] req_addr;
  logic [mem_pkg::WORD_W-1:0] req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [mem_pkg::WORD_W-1:0] rsp_rdata;
  logic                       rsp_err;
  logic                       busy;
  logic                       ld_we;
  logic                       ld_space;
  logic [mem_pkg::ADDR_W-1:0] ld_addr;
  logic [mem_pkg::WORD_W-1:0] ld_data;

  modport slave (
    input  req_valid, req_space, req_write, req_addr, req_wdata, rsp_ready,
           ld_we, ld_space, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport master (
    output req_valid, req_space, req_write, req_addr, req_wdata, rsp_ready,
           ld_we, ld_space, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_bank.sv
// Single-port synchronous word array, read-first; contents are never reset.
module mem_bank
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// One-outstanding-request responder over text and data banks with a programmable access latency.
// Preload owns the bank ports whenever the FSM is idle and ld_we is high.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              space_q, space_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              ld_sel;
  logic              access;
  logic              text_we, data_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [WORD_W-1:0] data_wdata;
  logic [WORD_W-1:0] text_rdata, data_rdata;

  assign ld_sel        = (state_q == IDLE) && bus.ld_we;
  assign access        = (state_q == WAIT) && (cnt_q == 4'd0);
  assign bus.req_ready = !reset && (state_q == IDLE) && !bus.ld_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    space_d = space_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          space_d = bus.req_space;
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      space_q <= SPACE_TEXT;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      space_q <= space_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outside a preload the banks keep reading the latched address, so read data holds through RESP.
  assign bank_addr  = ld_sel ? bus.ld_addr : addr_q;
  assign data_wdata = ld_sel ? bus.ld_data : wdata_q;
  assign text_we    = ld_sel && (bus.ld_space == SPACE_TEXT);
  assign data_we    = (ld_sel && (bus.ld_space == SPACE_DATA))
                   || (access && write_q && (space_q == SPACE_DATA));

  mem_bank u_text (
    .clk   (clk),
    .we    (text_we),
    .addr  (bank_addr),
    .wdata (bus.ld_data),
    .rdata (text_rdata)
  );

  mem_bank u_data (
    .clk   (clk),
    .we    (data_we),
    .addr  (bank_addr),
    .wdata (data_wdata),
    .rdata (data_rdata)
  );

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_err   = (state_q == RESP) && write_q && (space_q == SPACE_TEXT);
  assign bus.rsp_rdata = ((state_q == RESP) && !write_q)
                       ? ((space_q == SPACE_DATA) ? data_rdata : text_rdata)
                       : '0;
endmodule
